tlb_op_unit: RTL
================

// Module: tlb_op_unit
// PURPOSE
//  CP0-side initiator for the MMU TLB-instruction interface. Owns the Index, Random, Wired,
//  EntryHi, EntryLo0 and EntryLo1 registers. Sequences TLBP/TLBR/TLBWI/TLBWR ops from the
//  pipeline onto mmu_req_t, and captures mmu_resp_t results back into the registers.
//  Also applies the EntryHi.VPN2 update when the pipeline reports a TLB exception.
// PARAMETERS
//  TLB_ENTRIES  16  number of TLB entries; index width IW = $clog2(TLB_ENTRIES)
// PORTS
//  clk             in   1   clock
//  resetn          in   1   asynchronous active-low reset
//  op_valid        in   1   TLB instruction request from pipeline
//  op_type         in   2   00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
//  op_ready        out  1   unit idle; an op is accepted when op_valid & op_ready
//  op_done         out  1   one-cycle pulse when the op's effect is complete
//  cp0_we          in   1   MTC0 write strobe
//  cp0_waddr       in   5   CP0 register number: 0 Index, 2 Lo0, 3 Lo1, 6 Wired, 10 EntryHi
//  cp0_wdata       in   32  MTC0 data
//  tlb_exc_valid   in   1   TLB refill/invalid/modified exception committed
//  tlb_exc_vaddr   in   32  faulting virtual address
//  mmu_in          out  mmu_req_t   request to MMU: entry_hi/lo0/lo1, index, random, is_tlbwi/wr
//  mmu_out         in   mmu_resp_t  MMU response: index (TLBP result), entry_hi/lo0/lo1 (TLBR)
//  index_q, random_q, wired_q, entry_hi_q, entry_lo0_q, entry_lo1_q  out 32 each  (MFC0 view)
// BEHAVIOUR
//  Reset (async):
//   - All registers 0 except random_q = TLB_ENTRIES-1.
//   - op_ready=1, op_done=0, is_tlbwi=is_tlbwr=0; FSM -> IDLE.
//   - Reset mid-op aborts with no write pulse and no capture.
//  FSM: IDLE -> ISSUE -> (TLBP/TLBR: CAPTURE) -> IDLE.
//  - On accept at cycle T: snapshot Index, EntryHi, EntryLo0, EntryLo1 and random_q; go ISSUE.
//  - Writes (TLBWI/TLBWR):
//    - ISSUE at T+1 asserts exactly one of is_tlbwi/is_tlbwr for exactly that cycle.
//    - op_done at T+1; IDLE at T+2.
//  - TLBP/TLBR:
//    - ISSUE at T+1 presents the snapshot.
//    - CAPTURE at T+2 samples mmu_out; op_done at T+2; IDLE at T+3.
//    - TLBP writes index_q = {P, 0, index}.
//    - TLBR writes entry_hi_q, entry_lo0_q and entry_lo1_q from mmu_out.
//  - op_ready = (state==IDLE). op_valid while busy is ignored, not queued.
//  - mmu_in sources:
//    - In IDLE, mmu_in.entry_hi/lo/index mirror live registers, so translation ASID tracks EntryHi.
//    - Otherwise they carry the snapshot.
//    - is_tlbwi/is_tlbwr are 0 outside ISSUE.
//  - Random:
//    - Decrements every cycle.
//    - When random_q == wired_q (or wired_q >= TLB_ENTRIES-1), next value is TLB_ENTRIES-1.
//    - Any Wired write forces random_q = TLB_ENTRIES-1 in the following cycle.
//    - TLBWR uses the snapshotted value, not the live counter.
//  - MTC0 masking:
//    - Index: only [IW-1:0] is written; P is read-only.
//    - Wired: only [IW-1:0] is written.
//    - EntryLo: bits [31:26] read 0.
//    - EntryHi: bits [12:8] read 0.
//    - Random: not writable.
//  - tlb_exc_valid sets entry_hi_q.vpn2 = tlb_exc_vaddr[31:13]; ASID is unchanged.
//  - Same-cycle priority on a register: CAPTURE > tlb_exc_valid > cp0_we.
//  - MTC0 during a busy op updates live registers but not the in-flight snapshot.
// TESTING
//  1 Reset: release resetn -> random_q=15, op_ready=1, is_tlbwi=is_tlbwr=0, all other regs 0.
//  2 Random wrap: MTC0 Wired=4 -> random_q reads 15,14,...,4,15,14 on consecutive cycles;
//    with wired_q=15, random_q stays at 15.
//  3 TLBWI: Index=5, EntryHi=0x0040_2012, accept at T -> is_tlbwi=1 only at T+1 with index 5
//    and vpn2=0x00201; op_done at T+1; MTC0 EntryHi at T+1 does not alter mmu_in.
//  4 TLBP: response P=1 -> index_q=0x8000_0000; next probe with hit index 7
//    -> index_q=0x0000_0007; op_done at T+2 both times.
//  5 TLBR vs MTC0: CAPTURE with mmu_out.entry_hi=0x1234_A0FF while cp0_we writes EntryHi
//    -> entry_hi_q=0x1234_A0FF.
//  6 Reset mid-op: assert resetn=0 during ISSUE of TLBWR -> no is_tlbwr pulse after reset,
//    FSM in IDLE, op_ready=1.

Source files
------------

// File: rtl/tlb_op_unit.sv
// tlb_op_unit: CP0-side TLB register file and TLBP/TLBR/TLBWI/TLBWR sequencer toward the MMU.
package tlb_op_unit_pkg;
    typedef struct packed {
        logic [31:0] entry_hi;
        logic [31:0] entry_lo0;
        logic [31:0] entry_lo1;
        logic [31:0] index;
        logic [31:0] random;
        logic        is_tlbwi;
        logic        is_tlbwr;
    } mmu_req_t;
    typedef struct packed {
        logic        p;
        logic [31:0] index;
        logic [31:0] entry_hi;
        logic [31:0] entry_lo0;
        logic [31:0] entry_lo1;
    } mmu_resp_t;
endpackage

module tlb_op_unit
    import tlb_op_unit_pkg::*;
#(
    parameter int TLB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    output logic        op_ready,
    output logic        op_done,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic        tlb_exc_valid,
    input  logic [31:0] tlb_exc_vaddr,
    output mmu_req_t    mmu_in,
    input  mmu_resp_t   mmu_out,
    output logic [31:0] index_q,
    output logic [31:0] random_q,
    output logic [31:0] wired_q,
    output logic [31:0] entry_hi_q,
    output logic [31:0] entry_lo0_q,
    output logic [31:0] entry_lo1_q
);
    localparam int IW = $clog2(TLB_ENTRIES);
    localparam logic [31:0] RMAX = 32'(TLB_ENTRIES - 1);
    localparam logic [31:0] IMASK = (32'd1 << IW) - 32'd1;
    localparam logic [31:0] HI_MASK = 32'hFFFF_E0FF;
    localparam logic [31:0] LO_MASK = 32'h03FF_FFFF;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic        wi_q, wr_q;
    logic [31:0] snap_index, snap_hi, snap_lo0, snap_lo1, snap_random;
    logic        we_idx, we_lo0, we_lo1, we_wired, we_hi, cap_p, cap_r;

    assign op_ready = state == IDLE;
    assign we_idx   = cp0_we && cp0_waddr == 5'd0;
    assign we_lo0   = cp0_we && cp0_waddr == 5'd2;
    assign we_lo1   = cp0_we && cp0_waddr == 5'd3;
    assign we_wired = cp0_we && cp0_waddr == 5'd6;
    assign we_hi    = cp0_we && cp0_waddr == 5'd10;
    assign cap_p    = state == CAPTURE && !op_q[0];
    assign cap_r    = state == CAPTURE && op_q[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            op_q        <= 2'b00;
            op_done     <= 1'b0;
            wi_q        <= 1'b0;
            wr_q        <= 1'b0;
            snap_index  <= '0;
            snap_hi     <= '0;
            snap_lo0    <= '0;
            snap_lo1    <= '0;
            snap_random <= '0;
        end else begin
            op_done <= 1'b0;
            wi_q    <= 1'b0;
            wr_q    <= 1'b0;
            if (state == IDLE && op_valid) begin
                state       <= ISSUE;
                op_q        <= op_type;
                op_done     <= op_type[1];
                wi_q        <= op_type == 2'b10;
                wr_q        <= op_type == 2'b11;
                snap_index  <= index_q;
                snap_hi     <= entry_hi_q;
                snap_lo0    <= entry_lo0_q;
                snap_lo1    <= entry_lo1_q;
                snap_random <= random_q;
            end else if (state == ISSUE) begin
                state   <= op_q[1] ? IDLE : CAPTURE;
                op_done <= !op_q[1];
            end else if (state == CAPTURE) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_q     <= '0;
            random_q    <= RMAX;
            wired_q     <= '0;
            entry_hi_q  <= '0;
            entry_lo0_q <= '0;
            entry_lo1_q <= '0;
        end else begin
            random_q <= (we_wired || random_q == wired_q || wired_q >= RMAX) ? RMAX : random_q - 32'd1;
            if (cap_p)
                index_q <= {mmu_out.p, 31'b0} | (mmu_out.index & IMASK);
            else if (we_idx)
                index_q <= (index_q & 32'h8000_0000) | (cp0_wdata & IMASK);
            if (we_wired)
                wired_q <= cp0_wdata & IMASK;
            if (cap_r)
                entry_hi_q <= mmu_out.entry_hi & HI_MASK;
            else if (tlb_exc_valid)
                entry_hi_q <= (tlb_exc_vaddr & 32'hFFFF_E000) | (entry_hi_q & 32'h0000_1FFF);
            else if (we_hi)
                entry_hi_q <= cp0_wdata & HI_MASK;
            if (cap_r)
                entry_lo0_q <= mmu_out.entry_lo0 & LO_MASK;
            else if (we_lo0)
                entry_lo0_q <= cp0_wdata & LO_MASK;
            if (cap_r)
                entry_lo1_q <= mmu_out.entry_lo1 & LO_MASK;
            else if (we_lo1)
                entry_lo1_q <= cp0_wdata & LO_MASK;
        end
    end

    // Idle mirrors live registers so translation ASID follows EntryHi immediately
    always_comb begin
        mmu_in.entry_hi  = op_ready ? entry_hi_q : snap_hi;
        mmu_in.entry_lo0 = op_ready ? entry_lo0_q : snap_lo0;
        mmu_in.entry_lo1 = op_ready ? entry_lo1_q : snap_lo1;
        mmu_in.index     = op_ready ? index_q : snap_index;
        mmu_in.random    = op_ready ? random_q : snap_random;
        mmu_in.is_tlbwi  = wi_q;
        mmu_in.is_tlbwr  = wr_q;
    end
endmodule
